axi: RTL and testbench

AXI -- requirements
Module: axi

---
 rtl/axi.sv | 183 ++++++++++++++++++
 tb/tb_axi.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/axi.sv
// AXI4-Lite slave bridging to a simple request/done backend; independent write and read FSMs.
// Build option AXI_ERR_RESP_EN: backend error inputs complete a request with SLVERR.
module axi (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic [4:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [4:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        write,
  output logic [4:0]  write_addrs,
  output logic [31:0] write_data,
  output logic [3:0]  write_strobe,
  input  logic        write_done,
  input  logic        write_error,
  output logic        read,
  output logic [4:0]  read_addrs,
  input  logic [31:0] read_data,
  input  logic        read_done,
  input  logic        read_error
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_RESP = 2'd2} r_state_e;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_req_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic w_err, r_err;
`ifdef AXI_ERR_RESP_EN
  assign w_err = write_error;
  assign r_err = read_error;
`else
  logic unused_err;
  assign w_err      = 1'b0;
  assign r_err      = 1'b0;
  assign unused_err = write_error ^ read_error;
`endif

  // ---------------- write path ----------------
  w_state_e   w_state, w_next;
  wr_req_t    wreq, wreq_d;
  logic       aw_got, w_got, aw_got_d, w_got_d;
  logic       aw_hs, w_hs;
  logic       awready_d, wready_d, write_d, bvalid_d;
  logic [1:0] bresp_d;

  assign aw_hs        = s_axi_awvalid & s_axi_awready;
  assign w_hs         = s_axi_wvalid & s_axi_wready;
  assign write_addrs  = wreq.addr;
  assign write_data   = wreq.data;
  assign write_strobe = wreq.strb;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_aresetn) begin
      w_state       <= W_IDLE;
      aw_got        <= 1'b0;
      w_got         <= 1'b0;
      wreq          <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      write         <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      w_state       <= w_next;
      aw_got        <= aw_got_d;
      w_got         <= w_got_d;
      wreq          <= wreq_d;
      s_axi_awready <= awready_d;
      s_axi_wready  <= wready_d;
      write         <= write_d;
      s_axi_bvalid  <= bvalid_d;
      s_axi_bresp   <= bresp_d;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if ((aw_got | aw_hs) & (w_got | w_hs)) w_next = W_REQ;
      W_REQ:   if (write_done | w_err) w_next = W_RESP;
      W_RESP:  if (s_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // AW and W are captured independently; the "got" flags remember which half has arrived.
  always_comb begin
    wreq_d = wreq;
    if (aw_hs) wreq_d.addr = s_axi_awaddr;
    if (w_hs) begin
      wreq_d.data = s_axi_wdata;
      wreq_d.strb = s_axi_wstrb;
    end
    aw_got_d  = (w_state == W_IDLE) && (w_next == W_IDLE) && (aw_got | aw_hs);
    w_got_d   = (w_state == W_IDLE) && (w_next == W_IDLE) && (w_got | w_hs);
    awready_d = (w_next == W_IDLE) && !aw_got_d;
    wready_d  = (w_next == W_IDLE) && !w_got_d;
    write_d   = (w_next == W_REQ);
    bvalid_d  = (w_next == W_RESP);
    bresp_d   = RESP_OKAY;
    if (w_next == W_RESP)
      bresp_d = (w_state == W_REQ) ? (w_err ? RESP_SLVERR : RESP_OKAY) : s_axi_bresp;
  end

  // ---------------- read path ----------------
  r_state_e    r_state, r_next;
  logic        ar_hs;
  logic        arready_d, read_d, rvalid_d;
  logic [4:0]  raddr_d;
  logic [31:0] rdata_d;
  logic [1:0]  rresp_d;

  assign ar_hs = s_axi_arvalid & s_axi_arready;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_aresetn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      read          <= 1'b0;
      read_addrs    <= '0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      r_state       <= r_next;
      s_axi_arready <= arready_d;
      read          <= read_d;
      read_addrs    <= raddr_d;
      s_axi_rvalid  <= rvalid_d;
      s_axi_rdata   <= rdata_d;
      s_axi_rresp   <= rresp_d;
    end
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_REQ;
      R_REQ:   if (read_done | r_err) r_next = R_RESP;
      R_RESP:  if (s_axi_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    raddr_d   = ar_hs ? s_axi_araddr : read_addrs;
    arready_d = (r_next == R_IDLE);
    read_d    = (r_next == R_REQ);
    rvalid_d  = (r_next == R_RESP);
    rdata_d   = s_axi_rdata;
    rresp_d   = RESP_OKAY;
    if (r_next == R_RESP) begin
      if (r_state == R_REQ) begin
        rdata_d = read_data;
        rresp_d = r_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        rresp_d = s_axi_rresp;
      end
    end
  end

endmodule

// File: tb/tb_axi.sv
// Randomized + directed bench for axi, checked each cycle against a transaction-level model.
module tb_axi;
`ifdef AXI_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst;
  logic [4:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata, rd_in;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        write, write_done, write_error, read, read_done, read_error;
  logic [4:0]  write_addrs, read_addrs;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;

  int tests = 0, fails = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  axi dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .write(write), .write_addrs(write_addrs), .write_data(write_data), .write_strobe(write_strobe),
    .write_done(write_done), .write_error(write_error),
    .read(read), .read_addrs(read_addrs), .read_data(rd_in),
    .read_done(read_done), .read_error(read_error)
  );

  // Transaction-level model: tracks which handshakes have happened and what the bus must show.
  logic        m_awr, m_wr, m_have_aw, m_have_w, m_write, m_bvalid;
  logic [1:0]  m_bresp, m_rresp;
  logic [4:0]  m_waddr, m_raddr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_arr, m_read, m_rvalid;

  always @(posedge clk) begin
    if (rst) begin
      m_awr = 0; m_wr = 0; m_have_aw = 0; m_have_w = 0; m_write = 0; m_bvalid = 0;
      m_bresp = 0; m_waddr = 0; m_wdata = 0; m_wstrb = 0;
      m_arr = 0; m_read = 0; m_rvalid = 0; m_rresp = 0; m_raddr = 0; m_rdata = 0;
    end else begin
      if (m_bvalid) begin
        if (bready) begin m_bvalid = 0; m_bresp = 0; m_awr = 1; m_wr = 1; end
      end else if (m_write) begin
        if (write_done || (ERR_EN && write_error)) begin
          m_write = 0; m_bvalid = 1; m_bresp = (ERR_EN && write_error) ? 2'b10 : 2'b00;
        end
      end else begin
        if (awvalid && m_awr) begin m_have_aw = 1; m_waddr = awaddr; end
        if (wvalid && m_wr) begin m_have_w = 1; m_wdata = wdata; m_wstrb = wstrb; end
        if (m_have_aw && m_have_w) begin
          m_write = 1; m_have_aw = 0; m_have_w = 0; m_awr = 0; m_wr = 0;
        end else begin
          m_awr = !m_have_aw; m_wr = !m_have_w;
        end
      end
      if (m_rvalid) begin
        if (rready) begin m_rvalid = 0; m_rresp = 0; m_arr = 1; end
      end else if (m_read) begin
        if (read_done || (ERR_EN && read_error)) begin
          m_read = 0; m_rvalid = 1; m_rdata = rd_in;
          m_rresp = (ERR_EN && read_error) ? 2'b10 : 2'b00;
        end
      end else if (arvalid && m_arr) begin
        m_read = 1; m_raddr = araddr; m_arr = 0;
      end else begin
        m_arr = 1;
      end
    end
  end

  logic [46:0] wr_dut, wr_exp;
  logic [41:0] rd_dut, rd_exp;
  assign wr_dut = {awready, wready, bvalid, bresp, write, write_addrs, write_data, write_strobe};
  assign wr_exp = {m_awr, m_wr, m_bvalid, m_bresp, m_write, m_waddr, m_wdata, m_wstrb};
  assign rd_dut = {arready, rvalid, rresp, rdata, read, read_addrs};
  assign rd_exp = {m_arr, m_rvalid, m_rresp, m_rdata, m_read, m_raddr};

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (wr_dut !== wr_exp || rd_dut !== rd_exp) begin
        fails++;
        $display("FAIL cycle_cmp @%0t wr got=%h want=%h rd got=%h want=%h",
                 $time, wr_dut, wr_exp, rd_dut, rd_exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1; awaddr = 0; araddr = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0;
    rready = 0; wdata = 0; wstrb = 0; rd_in = 0; write_done = 0; write_error = 0;
    read_done = 0; read_error = 0;
    step(3);
    chk_en = 1;
    chk("rst_awready", awready, 0); chk("rst_write", write, 0);
    chk("rst_bvalid", bvalid, 0);   chk("rst_arready", arready, 0);
    rst = 0; step();
    chk("post_rst_awready", awready, 1); chk("post_rst_wready", wready, 1);
    chk("post_rst_arready", arready, 1);

    // same-cycle AW+W, then delayed bready
    awvalid = 1; awaddr = 12; wvalid = 1; wdata = 123; wstrb = 4'hF; step();
    chk("w22_write", write, 1); chk("w22_addr", write_addrs, 12);
    chk("w22_data", write_data, 123); chk("w22_strb", write_strobe, 4'hF);
    chk("w22_awready", awready, 0);
    awvalid = 0; wvalid = 0; write_done = 1; step(); write_done = 0;
    chk("w22_bvalid", bvalid, 1); chk("w22_bresp", bresp, 0); chk("w22_write_off", write, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bhold_bvalid", bvalid, 1); chk("bhold_awready", awready, 0);
    end
    bready = 1; step(); bready = 0;
    chk("b_clear", bvalid, 0); chk("b_awready_back", awready, 1);

    // W two cycles ahead of AW
    wvalid = 1; wdata = 5; wstrb = 4'h3; step(); wvalid = 0;
    chk("w24_wready", wready, 0); chk("w24_no_write", write, 0);
    step(); awvalid = 1; awaddr = 4; step(); awvalid = 0;
    chk("w24_write", write, 1); chk("w24_addr", write_addrs, 4); chk("w24_data", write_data, 5);
    write_done = 1; step(); write_done = 0; bready = 1; step(); bready = 0;
    chk("w24_done", bvalid, 0);

    // read
    arvalid = 1; araddr = 13; step(); arvalid = 0;
    chk("r23_read", read, 1); chk("r23_addr", read_addrs, 13); chk("r23_arready", arready, 0);
    rd_in = 1234; read_done = 1; step(); read_done = 0; rd_in = 0;
    chk("r23_rvalid", rvalid, 1); chk("r23_rdata", rdata, 1234); chk("r23_rresp", rresp, 0);
    rready = 1; step(); rready = 0;
    chk("r23_clear", rvalid, 0); chk("r23_arready_back", arready, 1);

    // backend error
    awvalid = 1; wvalid = 1; awaddr = 8; wdata = 77; step(); awvalid = 0; wvalid = 0;
    write_error = 1; step(); write_error = 0;
    if (ERR_EN) begin
      chk("err_bvalid", bvalid, 1); chk("err_bresp", bresp, 2);
    end else begin
      chk("noerr_write_held", write, 1); chk("noerr_no_bvalid", bvalid, 0);
      write_done = 1; step(); write_done = 0;
      chk("noerr_bvalid", bvalid, 1); chk("noerr_bresp", bresp, 0);
    end
    bready = 1; step(); bready = 0;

    // reset mid-request
    awvalid = 1; wvalid = 1; awaddr = 31; step(); awvalid = 0; wvalid = 0;
    chk("rst27_write", write, 1);
    rst = 1; write_done = 1; step(); write_done = 0;
    chk("rst27_write_off", write, 0); chk("rst27_no_bvalid", bvalid, 0);
    rst = 0; step();
    chk("rst27_awready", awready, 1); chk("rst27_bvalid", bvalid, 0);

    // random traffic, including occasional resets
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      awvalid     = $urandom_range(0, 2) == 0; awaddr = 5'($urandom);
      wvalid      = $urandom_range(0, 2) == 0; wdata  = $urandom; wstrb = 4'($urandom);
      bready      = $urandom_range(0, 1) == 0;
      write_done  = $urandom_range(0, 3) == 0;
      write_error = $urandom_range(0, 4) == 0;
      arvalid     = $urandom_range(0, 2) == 0; araddr = 5'($urandom);
      rready      = $urandom_range(0, 1) == 0;
      read_done   = $urandom_range(0, 3) == 0;
      read_error  = $urandom_range(0, 4) == 0;
      rd_in       = $urandom;
      step();
    end
    rst = 0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    write_done = 0; write_error = 0; read_done = 0; read_error = 0;
    step(2);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
